// File: rtl/clk_period_monitor.sv
// Slow-clock period monitor, measured in clk_in cycles.
// A 3-flop synchronizer feeds a rising-edge detector. The IDLE/RUN FSM
// measures the distance between rising edges, tracks lock against an
// expected period and reports loss of edges.
// Optional duty measurement: define CLK_MON_DUTY_EN to build the high-time
// counter. Without it, high_time_o is tied to zero and the ports stay the same.
module clk_period_monitor #(
    parameter int CNT_W      = 8,
    parameter int EXP_PERIOD = 50,
    parameter int TOL        = 2,
    parameter int LOCK_CNT   = 4,
    parameter int TIMEOUT    = 200
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             slow_clk,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_time_o,
    output logic             period_valid_o,
    output logic             locked_o,
    output logic             timeout_o
);

    localparam int GC_W = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W:0]   LO_BOUND = (CNT_W+1)'(EXP_PERIOD - TOL);
    localparam logic [CNT_W:0]   HI_BOUND = (CNT_W+1)'(EXP_PERIOD + TOL);
    localparam logic [CNT_W-1:0] TO_VAL   = CNT_W'(TIMEOUT);
    localparam logic [GC_W-1:0]  GC_MAX   = GC_W'(LOCK_CNT);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_reg, state_next;
    logic              s0_reg, s1_reg, s2_reg;
    logic              rise;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [CNT_W-1:0]  period_reg, period_next;
    logic              valid_reg, valid_next;
    logic              locked_reg, locked_next;
    logic              timeout_reg, timeout_next;
    logic [GC_W-1:0]   good_reg, good_next;
    logic [GC_W-1:0]   good_inc;
    logic [CNT_W:0]    meas;
    logic              meas_good;
    logic              timed_out;

    // Three-flop synchronizer on the asynchronous slow clock
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            s0_reg <= 1'b0;
            s1_reg <= 1'b0;
            s2_reg <= 1'b0;
        end else begin
            s0_reg <= slow_clk;
            s1_reg <= s0_reg;
            s2_reg <= s1_reg;
        end
    end

    assign rise      = s1_reg & ~s2_reg;
    // Measured period is cnt+1, widened so that TIMEOUT+1 compares correctly
    assign meas      = {1'b0, cnt_reg} + {{CNT_W{1'b0}}, 1'b1};
    assign meas_good = (meas >= LO_BOUND) && (meas <= HI_BOUND);
    assign good_inc  = (good_reg == GC_MAX) ? good_reg : good_reg + 1'b1;
    // A rise on the TIMEOUT cycle takes priority and is measured normally
    assign timed_out = (state_reg == RUN) && !rise && (cnt_reg == TO_VAL);

    // Next-state, measurement and lock logic
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        period_next  = period_reg;
        valid_next   = 1'b0;
        locked_next  = locked_reg;
        timeout_next = 1'b0;
        good_next    = good_reg;
        case (state_reg)
            IDLE: begin
                // The first edge only starts the counter; no period exists yet
                if (rise) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end
            end
            RUN: begin
                if (rise) begin
                    cnt_next    = '0;
                    period_next = meas[CNT_W-1:0];
                    valid_next  = 1'b1;
                    if (meas_good) begin
                        good_next   = good_inc;
                        locked_next = (good_inc == GC_MAX);
                    end else begin
                        good_next   = '0;
                        locked_next = 1'b0;
                    end
                end else if (timed_out) begin
                    // Edges lost: drop lock, keep the last period on display
                    state_next   = IDLE;
                    cnt_next     = '0;
                    timeout_next = 1'b1;
                    locked_next  = 1'b0;
                    good_next    = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and output registers; a reset discards any partial period
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            period_reg  <= '0;
            valid_reg   <= 1'b0;
            locked_reg  <= 1'b0;
            timeout_reg <= 1'b0;
            good_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            period_reg  <= period_next;
            valid_reg   <= valid_next;
            locked_reg  <= locked_next;
            timeout_reg <= timeout_next;
            good_reg    <= good_next;
        end
    end

`ifdef CLK_MON_DUTY_EN
    logic [CNT_W-1:0] hcnt_reg, hcnt_next;
    logic [CNT_W-1:0] high_reg, high_next;

    // High-time counter; the rise cycle's own sample is included in the result
    always_comb begin
        hcnt_next = hcnt_reg;
        high_next = high_reg;
        if (state_reg == RUN) begin
            if (rise) begin
                high_next = hcnt_reg + CNT_W'(s2_reg);
                hcnt_next = '0;
            end else if (timed_out) begin
                hcnt_next = '0;
            end else begin
                hcnt_next = hcnt_reg + CNT_W'(s2_reg);
            end
        end
    end

    // High-time registers
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            hcnt_reg <= '0;
            high_reg <= '0;
        end else begin
            hcnt_reg <= hcnt_next;
            high_reg <= high_next;
        end
    end

    assign high_time_o = high_reg;
`else
    assign high_time_o = '0;
`endif

    assign period_o       = period_reg;
    assign period_valid_o = valid_reg;
    assign locked_o       = locked_reg;
    assign timeout_o      = timeout_reg;

endmodule
